// File: rtl/simmem_pkg.sv
// Shared types and default sizing for the simulated-memory latency slot bank.
package simmem_pkg;

  // Default configuration; the slot bank module parameters default to these.
  localparam int LatNumIds     = 4;
  localparam int LatNumSlots   = 8;
  localparam int LatDelayWidth = 8;
  localparam int LatDataWidth  = 8;

  localparam int LatIdWidth  = $clog2(LatNumIds);
  // One extra bit over the slot index so a sequence number never aliases
  // while every slot of one ID is outstanding.
  localparam int LatSeqWidth = $clog2(LatNumSlots) + 1;

  // Contents of one reservation slot at the default configuration.
  typedef struct packed {
    logic                     used;
    logic [LatIdWidth-1:0]    id;
    logic [LatSeqWidth-1:0]   seq;
    logic [LatDelayWidth-1:0] cnt;
    logic                     filled;
    logic [LatDataWidth-1:0]  data;
  } lat_slot_t;

endpackage

// File: rtl/simmem_prio_pick.sv
// Lowest-index picker: one-hot of the lowest set request bit plus its index.
module simmem_prio_pick #(
  parameter int Width = 8,
  localparam int IdxWidth = $clog2(Width)
) (
  input  logic [Width-1:0]    req,
  output logic [Width-1:0]    onehot,
  output logic [IdxWidth-1:0] idx
);

  // Isolate the lowest set bit and encode it; the encoder is an OR of
  // one-hot-gated indices, so no priority chain is needed.
  always_comb begin
    onehot = req & (~req + Width'(1));
    idx    = '0;
    for (int i = 0; i < Width; i++) begin
      idx = idx | (IdxWidth'(i) & {IdxWidth{onehot[i]}});
    end
  end

endmodule

// File: rtl/simmem_lat_slots.sv
// Latency-injection slot bank: requests reserve a slot, responses fill the
// oldest outstanding slot of their ID, and slots release in per-ID order once
// their programmed delay has expired.
// Optional build macro SIMMEM_LAT_STATS_EN adds a saturating release counter.
module simmem_lat_slots
  import simmem_pkg::*;
#(
  parameter int NumIds     = LatNumIds,
  parameter int NumSlots   = LatNumSlots,
  parameter int DataWidth  = LatDataWidth,
  parameter int DelayWidth = LatDelayWidth,
  localparam int IdWidth      = $clog2(NumIds),
  localparam int SlotIdxWidth = $clog2(NumSlots),
  localparam int SeqWidth     = SlotIdxWidth + 1,
  localparam int OccWidth     = $clog2(NumSlots + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  req_in_valid_i,
  output logic                  req_in_ready_o,
  output logic                  req_out_valid_o,
  input  logic                  req_out_ready_i,
  input  logic [IdWidth-1:0]    req_id_i,
  input  logic                  rsp_in_valid_i,
  output logic                  rsp_in_ready_o,
  input  logic [IdWidth-1:0]    rsp_in_id_i,
  input  logic [DataWidth-1:0]  rsp_in_data_i,
  output logic                  rsp_out_valid_o,
  input  logic                  rsp_out_ready_i,
  output logic [IdWidth-1:0]    rsp_out_id_o,
  output logic [DataWidth-1:0]  rsp_out_data_o,
`ifdef SIMMEM_LAT_STATS_EN
  output logic [15:0]           released_cnt_o,
`endif
  output logic [OccWidth-1:0]   occupancy_o
);

  // Same layout as simmem_pkg::lat_slot_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  used;
    logic [IdWidth-1:0]    id;
    logic [SeqWidth-1:0]   seq;
    logic [DelayWidth-1:0] cnt;
    logic                  filled;
    logic [DataWidth-1:0]  data;
  } slot_t;

  slot_t               slots    [NumSlots];
  logic [SeqWidth-1:0] rsv_seq  [NumIds];
  logic [SeqWidth-1:0] fill_seq [NumIds];
  logic [SeqWidth-1:0] rel_seq  [NumIds];

  logic [NumSlots-1:0]     free_vec;
  logic [NumSlots-1:0]     fill_match;
  logic [NumSlots-1:0]     elig_vec;
  logic [NumSlots-1:0]     free_oh;
  logic [NumSlots-1:0]     rel_oh;
  logic [SlotIdxWidth-1:0] free_idx;
  logic [SlotIdxWidth-1:0] rel_pick_idx;
  logic [SlotIdxWidth-1:0] fill_idx;
  logic [SlotIdxWidth-1:0] rel_idx;
  logic [SlotIdxWidth-1:0] hold_idx;
  logic                    hold;
  logic                    free_any;
  logic                    rel_any;
  logic                    do_reserve;
  logic                    do_fill;
  logic                    do_release;

  // Per-slot status vectors: free, fill target and release eligibility.
  always_comb begin
    free_vec   = '0;
    fill_match = '0;
    elig_vec   = '0;
    fill_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      free_vec[i]   = ~slots[i].used;
      fill_match[i] = slots[i].used & ~slots[i].filled &
                      (slots[i].id == rsp_in_id_i) &
                      (slots[i].seq == fill_seq[rsp_in_id_i]);
      elig_vec[i]   = slots[i].used & slots[i].filled &
                      (slots[i].cnt == '0) &
                      (slots[i].seq == rel_seq[slots[i].id]);
      // At most one slot matches a fill, so an OR-encode gives its index.
      fill_idx      = fill_idx | (SlotIdxWidth'(i) & {SlotIdxWidth{fill_match[i]}});
    end
  end

  simmem_prio_pick #(.Width(NumSlots)) u_free_pick (
    .req    (free_vec),
    .onehot (free_oh),
    .idx    (free_idx)
  );

  simmem_prio_pick #(.Width(NumSlots)) u_rel_pick (
    .req    (elig_vec),
    .onehot (rel_oh),
    .idx    (rel_pick_idx)
  );

  // Handshake decode; a stalled release keeps its slot so the output is stable.
  always_comb begin
    free_any        = |free_oh;
    rel_any         = |rel_oh;
    req_in_ready_o  = req_out_ready_i & free_any;
    req_out_valid_o = req_in_valid_i & free_any;
    do_reserve      = req_in_valid_i & req_out_ready_i & free_any;
    rsp_in_ready_o  = |fill_match;
    do_fill         = rsp_in_valid_i & rsp_in_ready_o;
    rsp_out_valid_o = hold | rel_any;
    rel_idx         = hold ? hold_idx : rel_pick_idx;
    do_release      = rsp_out_valid_o & rsp_out_ready_i;
  end

  // Released payload, forced to zero when nothing is being offered.
  always_comb begin
    if (rsp_out_valid_o) begin
      rsp_out_id_o   = slots[rel_idx].id;
      rsp_out_data_o = slots[rel_idx].data;
    end else begin
      rsp_out_id_o   = '0;
      rsp_out_data_o = '0;
    end
  end

  // Number of non-free slots.
  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      occupancy_o = occupancy_o + OccWidth'(slots[i].used);
    end
  end

  // Slot state and per-ID sequence counters; reserve, fill and release always
  // hit distinct slots, so all three may update in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        slots[i] <= '0;
      end
      for (int j = 0; j < NumIds; j++) begin
        rsv_seq[j]  <= '0;
        fill_seq[j] <= '0;
        rel_seq[j]  <= '0;
      end
      hold     <= 1'b0;
      hold_idx <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (slots[i].used && (slots[i].cnt != '0)) begin
          slots[i].cnt <= slots[i].cnt - DelayWidth'(1);
        end
      end
      if (do_reserve) begin
        slots[free_idx] <= '{used:   1'b1,
                             id:     req_id_i,
                             seq:    rsv_seq[req_id_i],
                             cnt:    delay_i,
                             filled: 1'b0,
                             data:   '0};
        rsv_seq[req_id_i] <= rsv_seq[req_id_i] + SeqWidth'(1);
      end
      if (do_fill) begin
        slots[fill_idx].filled   <= 1'b1;
        slots[fill_idx].data     <= rsp_in_data_i;
        fill_seq[rsp_in_id_i]    <= fill_seq[rsp_in_id_i] + SeqWidth'(1);
      end
      if (do_release) begin
        slots[rel_idx].used          <= 1'b0;
        rel_seq[slots[rel_idx].id]   <= rel_seq[slots[rel_idx].id] + SeqWidth'(1);
      end
      hold     <= rsp_out_valid_o & ~rsp_out_ready_i;
      hold_idx <= rel_idx;
    end
  end

`ifdef SIMMEM_LAT_STATS_EN
  // Saturating count of completed downstream response handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      released_cnt_o <= 16'd0;
    end else if (do_release && (released_cnt_o != 16'hFFFF)) begin
      released_cnt_o <= released_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simmem_lat_slots.sv
// Directed self-checking bench for simmem_lat_slots (default parameters).
module tb_simmem_lat_slots;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] delay_i;
  logic       req_in_valid_i;
  logic       req_in_ready_o;
  logic       req_out_valid_o;
  logic       req_out_ready_i;
  logic [1:0] req_id_i;
  logic       rsp_in_valid_i;
  logic       rsp_in_ready_o;
  logic [1:0] rsp_in_id_i;
  logic [7:0] rsp_in_data_i;
  logic       rsp_out_valid_o;
  logic       rsp_out_ready_i;
  logic [1:0] rsp_out_id_o;
  logic [7:0] rsp_out_data_o;
  logic [3:0] occupancy_o;
`ifdef SIMMEM_LAT_STATS_EN
  logic [15:0] released_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  simmem_lat_slots dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .delay_i         (delay_i),
    .req_in_valid_i  (req_in_valid_i),
    .req_in_ready_o  (req_in_ready_o),
    .req_out_valid_o (req_out_valid_o),
    .req_out_ready_i (req_out_ready_i),
    .req_id_i        (req_id_i),
    .rsp_in_valid_i  (rsp_in_valid_i),
    .rsp_in_ready_o  (rsp_in_ready_o),
    .rsp_in_id_i     (rsp_in_id_i),
    .rsp_in_data_i   (rsp_in_data_i),
    .rsp_out_valid_o (rsp_out_valid_o),
    .rsp_out_ready_i (rsp_out_ready_i),
    .rsp_out_id_o    (rsp_out_id_o),
    .rsp_out_data_o  (rsp_out_data_o),
`ifdef SIMMEM_LAT_STATS_EN
    .released_cnt_o  (released_cnt_o),
`endif
    .occupancy_o     (occupancy_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next active edge, where inputs are driven.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_in_valid_i  = 1'b0;
    req_id_i        = 2'd0;
    delay_i         = 8'd0;
    req_out_ready_i = 1'b1;
    rsp_in_valid_i  = 1'b0;
    rsp_in_id_i     = 2'd0;
    rsp_in_data_i   = 8'd0;
    rsp_out_ready_i = 1'b1;
  endtask

  // Idle after reset: outputs cleared, request handshake follows the inputs.
  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      req_out_ready_i = (k % 2 == 1);
      req_in_valid_i  = (k % 2 == 0);
      rsp_in_valid_i  = 1'b1;
      rsp_in_id_i     = 2'(k);
      @(negedge clk_i);
      checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL reset_occ k=%0d: got %0d want 0", k, occupancy_o); end
      checks++; if (rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_outv k=%0d: got %b want 0", k, rsp_out_valid_o); end
      checks++; if (rsp_out_data_o !== 8'h00 || rsp_out_id_o !== 2'd0) begin failures++; $display("FAIL reset_outd k=%0d: got id %0d data %h want 0/00", k, rsp_out_id_o, rsp_out_data_o); end
      checks++; if (req_in_ready_o !== (k % 2 == 1)) begin failures++; $display("FAIL reset_reqrdy k=%0d: got %b want %b", k, req_in_ready_o, (k % 2 == 1)); end
      checks++; if (req_out_valid_o !== (k % 2 == 0)) begin failures++; $display("FAIL reset_reqval k=%0d: got %b want %b", k, req_out_valid_o, (k % 2 == 0)); end
      checks++; if (rsp_in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_rsprdy k=%0d: got %b want 0", k, rsp_in_ready_o); end
      tick();
    end
    idle_inputs();
  endtask

  // ID 1, delay 5 accepted at cycle t, response at t+2: out valid at t+6.
  task automatic test_single();
    logic exp_v;
    req_in_valid_i = 1'b1; req_id_i = 2'd1; delay_i = 8'd5;
    @(negedge clk_i);
    checks++; if (req_in_ready_o !== 1'b1) begin failures++; $display("FAIL single_accept: got %b want 1", req_in_ready_o); end
    tick();
    req_in_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      rsp_in_valid_i  = (k == 2);
      rsp_in_id_i     = 2'd1;
      rsp_in_data_i   = 8'hA5;
      rsp_out_ready_i = (k == 8);
      @(negedge clk_i);
      if (k == 1) begin
        checks++; if (occupancy_o !== 4'd1) begin failures++; $display("FAIL single_occ1: got %0d want 1", occupancy_o); end
      end
      if (k == 2) begin
        checks++; if (rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL single_fill_rdy: got %b want 1", rsp_in_ready_o); end
      end
      exp_v = (k >= 6 && k <= 8);
      checks++; if (rsp_out_valid_o !== exp_v) begin failures++; $display("FAIL single_valid k=%0d: got %b want %b", k, rsp_out_valid_o, exp_v); end
      if (exp_v) begin
        checks++; if (rsp_out_id_o !== 2'd1 || rsp_out_data_o !== 8'hA5) begin failures++; $display("FAIL single_payload k=%0d: got id %0d data %h want 1/a5", k, rsp_out_id_o, rsp_out_data_o); end
      end
      if (k == 9) begin
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL single_occ0: got %0d want 0", occupancy_o); end
      end
      tick();
    end
    idle_inputs();
  endtask

  // Two ID-2 requests (delay 10, then 0) answered at once: A then B.
  task automatic test_order();
    logic       exp_v;
    logic [7:0] exp_d;
    for (int k = 0; k <= 16; k++) begin
      req_in_valid_i = (k < 2);
      req_id_i       = 2'd2;
      delay_i        = (k == 0) ? 8'd10 : 8'd0;
      rsp_in_valid_i = (k == 2 || k == 3);
      rsp_in_id_i    = 2'd2;
      rsp_in_data_i  = (k == 2) ? 8'h11 : 8'h22;
      @(negedge clk_i);
      if (k == 2 || k == 3) begin
        checks++; if (rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL order_fill_rdy k=%0d: got %b want 1", k, rsp_in_ready_o); end
      end
      exp_v = (k == 11 || k == 12);
      exp_d = (k == 11) ? 8'h11 : ((k == 12) ? 8'h22 : 8'h00);
      checks++; if (rsp_out_valid_o !== exp_v) begin failures++; $display("FAIL order_valid k=%0d: got %b want %b", k, rsp_out_valid_o, exp_v); end
      checks++; if (rsp_out_data_o !== exp_d || rsp_out_id_o !== (exp_v ? 2'd2 : 2'd0)) begin failures++; $display("FAIL order_payload k=%0d: got id %0d data %h want data %h", k, rsp_out_id_o, rsp_out_data_o, exp_d); end
      tick();
    end
    idle_inputs();
  endtask

  // All eight slots used: request side blocked until a slot is released.
  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      req_in_valid_i = 1'b1; req_id_i = 2'(k); delay_i = 8'd3;
      @(negedge clk_i);
      checks++; if (req_in_ready_o !== 1'b1) begin failures++; $display("FAIL full_fill_rdy k=%0d: got %b want 1", k, req_in_ready_o); end
      tick();
    end
    @(negedge clk_i);
    checks++; if (occupancy_o !== 4'd8) begin failures++; $display("FAIL full_occ8: got %0d want 8", occupancy_o); end
    checks++; if (req_in_ready_o !== 1'b0 || req_out_valid_o !== 1'b0) begin failures++; $display("FAIL full_block_rdy1: got rdy %b val %b want 0/0", req_in_ready_o, req_out_valid_o); end
    tick();
    req_out_ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (req_in_ready_o !== 1'b0 || req_out_valid_o !== 1'b0) begin failures++; $display("FAIL full_block_rdy0: got rdy %b val %b want 0/0", req_in_ready_o, req_out_valid_o); end
    tick();
    req_in_valid_i = 1'b0; req_out_ready_i = 1'b1;
    rsp_in_valid_i = 1'b1; rsp_in_id_i = 2'd0; rsp_in_data_i = 8'h5A;
    @(negedge clk_i);
    checks++; if (rsp_in_ready_o !== 1'b1 || rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL full_fill: got rdy %b outv %b want 1/0", rsp_in_ready_o, rsp_out_valid_o); end
    tick();
    rsp_in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rsp_out_valid_o !== 1'b1 || rsp_out_id_o !== 2'd0 || rsp_out_data_o !== 8'h5A) begin failures++; $display("FAIL full_release: got v %b id %0d data %h want 1/0/5a", rsp_out_valid_o, rsp_out_id_o, rsp_out_data_o); end
    checks++; if (req_in_ready_o !== 1'b0) begin failures++; $display("FAIL full_rdy_same_cycle: got %b want 0", req_in_ready_o); end
    tick();
    @(negedge clk_i);
    checks++; if (req_in_ready_o !== 1'b1 || occupancy_o !== 4'd7 || rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL full_after_release: got rdy %b occ %0d outv %b want 1/7/0", req_in_ready_o, occupancy_o, rsp_out_valid_o); end
    idle_inputs();
  endtask

  // Reset with seven slots outstanding discards everything.
  task automatic test_reset_mid();
    rsp_in_id_i = 2'd1;
    @(negedge clk_i);
    checks++; if (rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL mid_pre_rdy: got %b want 1", rsp_in_ready_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (occupancy_o !== 4'd0 || rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL mid_cleared: got occ %0d outv %b want 0/0", occupancy_o, rsp_out_valid_o); end
    checks++; if (rsp_in_ready_o !== 1'b0 || req_in_ready_o !== 1'b1) begin failures++; $display("FAIL mid_handshake: got rsprdy %b reqrdy %b want 0/1", rsp_in_ready_o, req_in_ready_o); end
    tick();
    idle_inputs();
  endtask

  // Unreserved ID 3 response waits, then fills once a reservation appears.
  task automatic test_orphan();
    rsp_in_valid_i = 1'b1; rsp_in_id_i = 2'd3; rsp_in_data_i = 8'h3C;
    for (int k = 0; k <= 9; k++) begin
      req_in_valid_i = (k == 6); req_id_i = 2'd3; delay_i = 8'd0;
      if (k >= 8) rsp_in_valid_i = 1'b0;
      @(negedge clk_i);
      if (k <= 6) begin
        checks++; if (rsp_in_ready_o !== 1'b0 || rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL orphan_stall k=%0d: got rdy %b outv %b want 0/0", k, rsp_in_ready_o, rsp_out_valid_o); end
      end
      if (k == 7) begin
        checks++; if (rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL orphan_fill_rdy: got %b want 1", rsp_in_ready_o); end
      end
      if (k == 8) begin
        checks++; if (rsp_out_valid_o !== 1'b1 || rsp_out_id_o !== 2'd3 || rsp_out_data_o !== 8'h3C) begin failures++; $display("FAIL orphan_out: got v %b id %0d data %h want 1/3/3c", rsp_out_valid_o, rsp_out_id_o, rsp_out_data_o); end
      end
      if (k == 9) begin
        checks++; if (occupancy_o !== 4'd0 || rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL orphan_done: got occ %0d outv %b want 0/0", occupancy_o, rsp_out_valid_o); end
      end
      tick();
    end
    idle_inputs();
  endtask

  // Reserve (ID 0), fill (ID 0 older slot) and release (ID 1) in one cycle.
  task automatic test_simul();
    rsp_out_ready_i = 1'b0;
    req_in_valid_i = 1'b1; req_id_i = 2'd1;
    tick();
    req_id_i = 2'd0;
    tick();
    req_in_valid_i = 1'b0;
    rsp_in_valid_i = 1'b1; rsp_in_id_i = 2'd1; rsp_in_data_i = 8'h77;
    @(negedge clk_i);
    checks++; if (rsp_out_valid_o !== 1'b0) begin failures++; $display("FAIL simul_early: got %b want 0", rsp_out_valid_o); end
    tick();
    rsp_in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rsp_out_valid_o !== 1'b1 || rsp_out_data_o !== 8'h77 || occupancy_o !== 4'd2) begin failures++; $display("FAIL simul_setup: got v %b data %h occ %0d want 1/77/2", rsp_out_valid_o, rsp_out_data_o, occupancy_o); end
    tick();
    req_in_valid_i = 1'b1; req_id_i = 2'd0;
    rsp_in_valid_i = 1'b1; rsp_in_id_i = 2'd0; rsp_in_data_i = 8'h88;
    rsp_out_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (req_in_ready_o !== 1'b1 || rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL simul_rdys: got reqrdy %b rsprdy %b want 1/1", req_in_ready_o, rsp_in_ready_o); end
    checks++; if (rsp_out_valid_o !== 1'b1 || rsp_out_id_o !== 2'd1 || rsp_out_data_o !== 8'h77) begin failures++; $display("FAIL simul_rel: got v %b id %0d data %h want 1/1/77", rsp_out_valid_o, rsp_out_id_o, rsp_out_data_o); end
    tick();
    req_in_valid_i = 1'b0; rsp_in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (occupancy_o !== 4'd2) begin failures++; $display("FAIL simul_occ: got %0d want 2", occupancy_o); end
    checks++; if (rsp_out_valid_o !== 1'b1 || rsp_out_id_o !== 2'd0 || rsp_out_data_o !== 8'h88) begin failures++; $display("FAIL simul_next: got v %b id %0d data %h want 1/0/88", rsp_out_valid_o, rsp_out_id_o, rsp_out_data_o); end
    tick();
    @(negedge clk_i);
    checks++; if (occupancy_o !== 4'd1 || rsp_out_valid_o !== 1'b0 || rsp_in_ready_o !== 1'b1) begin failures++; $display("FAIL simul_tail: got occ %0d outv %b rsprdy %b want 1/0/1", occupancy_o, rsp_out_valid_o, rsp_in_ready_o); end
    tick();
    idle_inputs();
  endtask

  // Test sequence.
  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    test_reset();
    test_single();
    test_order();
    test_full();
    test_reset_mid();
    test_orphan();
    test_simul();
`ifdef SIMMEM_LAT_STATS_EN
    checks++; if (released_cnt_o !== 16'd3) begin failures++; $display("FAIL stats_count: got %0d want 3", released_cnt_o); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
